// File: rtl/dp_store.sv
// -----------------------------------------------------------------------------
// dp_store
//
// Purpose:
//   Datapoint store that sits downstream of the serial deserializer. While in
//   LOAD it captures each completed datapoint word (features + y) into an
//   internal synchronous RAM at the presented address. When load_done is seen,
//   it streams the stored datapoints back, one LENGTH-bit lane per transfer,
//   datapoint-major / lane-minor, over a valid/ready handshake.
//
// Optional feature:
//   DP_STORE_REPLAY_EN - adds the 'replay' input. A replay pulse in DONE
//   restarts streaming from datapoint 0 with the latched feat/num_dp.
//   When undefined, DONE is terminal until reset.
//
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous active-high reset
//   num_dp     last datapoint index (latched when load_done is accepted)
//   feat       feature count, lanes used = feat+1 (latched with load_done)
//   wr_en      write strobe, one cycle per completed word (LOAD only)
//   wr_addr    datapoint index of the write
//   wr_data    datapoint word
//   load_done  end of loading (level)
//   replay     restart streaming from DONE (DP_STORE_REPLAY_EN only)
//   out_data   current lane value
//   out_lane   lane index 0..feat
//   out_dp     datapoint index
//   out_is_y   current lane is the y value (lane == feat)
//   out_last   final lane of the final datapoint
//   out_valid  output lane valid
//   out_ready  consumer accepts the lane
//   overflow   sticky: a write was dropped because wr_addr >= DEPTH
//   done       streaming finished
// -----------------------------------------------------------------------------
module dp_store #(
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned MAX_FEATURES = 15,
    parameter int unsigned LENGTH       = 16,
    parameter int unsigned DATA_WIDTH   = LENGTH * (MAX_FEATURES + 1),
    parameter int unsigned DEPTH        = 100,
    localparam int unsigned LANE_W      = $clog2(MAX_FEATURES + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] num_dp,
    input  logic [LANE_W-1:0]     feat,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  load_done,
`ifdef DP_STORE_REPLAY_EN
    input  logic                  replay,
`endif
    output logic [LENGTH-1:0]     out_data,
    output logic [LANE_W-1:0]     out_lane,
    output logic [ADDR_WIDTH-1:0] out_dp,
    output logic                  out_is_y,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow,
    output logic                  done
);

    localparam int unsigned            MEM_AW    = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [LANE_W-1:0]      MAX_LANE  = LANE_W'(MAX_FEATURES);

    typedef enum logic [1:0] {
        S_LOAD,
        S_FETCH,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                  state_q,    state_d;
    logic [LANE_W-1:0]       lane_q,     lane_d;
    logic [ADDR_WIDTH-1:0]   dp_q,       dp_d;
    logic [LANE_W-1:0]       feat_q,     feat_d;
    logic [ADDR_WIDTH-1:0]   last_dp_q,  last_dp_d;
    logic                    overflow_q, overflow_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic                    wr_in_range;
    logic                    mem_we;
    logic                    emit;
    logic                    at_y;
    logic [LANE_W-1:0]       lane_sel;
    logic [LENGTH-1:0]       lanes [MAX_FEATURES+1];

    assign wr_in_range = (wr_addr <= LAST_ADDR);
    assign mem_we      = (state_q == S_LOAD) && wr_en && wr_in_range;

    // RAM: no reset, contents survive RST. Read port is registered in FETCH.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[wr_addr[MEM_AW-1:0]] <= wr_data;
        end
        if (state_q == S_FETCH) begin
            rdata_q <= mem[dp_q[MEM_AW-1:0]];
        end
    end

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        dp_d       = dp_q;
        feat_d     = feat_q;
        last_dp_d  = last_dp_q;
        overflow_d = overflow_q;

        case (state_q)
            S_LOAD: begin
                if (wr_en && !wr_in_range) begin
                    overflow_d = 1'b1;
                end
                // A write in the same cycle as load_done still lands (mem_we).
                if (load_done) begin
                    feat_d    = feat;
                    last_dp_d = (num_dp > LAST_ADDR) ? LAST_ADDR : num_dp;
                    dp_d      = '0;
                    lane_d    = '0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                lane_d  = '0;
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (lane_q != feat_q) begin
                        lane_d = lane_q + 1'b1;
                    end else if (dp_q != last_dp_q) begin
                        dp_d    = dp_q + 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
`ifdef DP_STORE_REPLAY_EN
                if (replay) begin
                    dp_d    = '0;
                    lane_d  = '0;
                    state_d = S_FETCH;
                end
`endif
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_LOAD;
            lane_q     <= '0;
            dp_q       <= '0;
            feat_q     <= '0;
            last_dp_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            dp_q       <= dp_d;
            feat_q     <= feat_d;
            last_dp_q  <= last_dp_d;
            overflow_q <= overflow_d;
        end
    end

    // Split the registered word into lanes; used lanes are packed against the
    // top of the word, so lane j lives at physical lane (MAX_FEATURES-feat+j).
    always_comb begin
        for (int unsigned i = 0; i <= MAX_FEATURES; i++) begin
            lanes[i] = rdata_q[i*LENGTH +: LENGTH];
        end
    end

    assign lane_sel = MAX_LANE - feat_q + lane_q;
    assign emit     = (state_q == S_EMIT);
    assign at_y     = (lane_q == feat_q);

    // Outputs are gated by EMIT so everything reads zero outside streaming,
    // including immediately on an asynchronous reset.
    assign out_valid = emit;
    assign done      = (state_q == S_DONE);
    assign overflow  = overflow_q;
    assign out_data  = emit ? lanes[lane_sel] : '0;
    assign out_lane  = emit ? lane_q : '0;
    assign out_dp    = emit ? dp_q : '0;
    assign out_is_y  = emit && at_y;
    assign out_last  = emit && at_y && (dp_q == last_dp_q);

endmodule

// File: tb/tb_dp_store.sv
module tb_dp_store;

    localparam int DEPTH = 100;

    logic         CLK = 1'b0;
    logic         RST;
    logic [11:0]  num_dp;
    logic [3:0]   feat;
    logic         wr_en;
    logic [11:0]  wr_addr;
    logic [255:0] wr_data;
    logic         load_done;
`ifdef DP_STORE_REPLAY_EN
    logic         replay;
`endif
    logic [15:0]  out_data;
    logic [3:0]   out_lane;
    logic [11:0]  out_dp;
    logic         out_is_y;
    logic         out_last;
    logic         out_valid;
    logic         out_ready;
    logic         overflow;
    logic         done;

    always #5 CLK = ~CLK;

    dp_store dut (
        .CLK       (CLK),
        .RST       (RST),
        .num_dp    (num_dp),
        .feat      (feat),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .load_done (load_done),
`ifdef DP_STORE_REPLAY_EN
        .replay    (replay),
`endif
        .out_data  (out_data),
        .out_lane  (out_lane),
        .out_dp    (out_dp),
        .out_is_y  (out_is_y),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .done      (done)
    );

    typedef struct packed {
        logic [11:0] dp;
        logic [3:0]  lane;
        logic [15:0] data;
        logic        is_y;
        logic        last;
    } xfer_t;

    logic [255:0] model_mem [DEPTH];
    xfer_t        exp_q[$];
    xfer_t        obs_q[$];
    int           gap_q[$];
    int           stall_changes;
    int           n_vec  = 0;
    int           n_fail = 0;

    function automatic logic [255:0] rand_word();
        logic [255:0] w = '0;
        for (int i = 0; i < 8; i++) w = {w[223:0], 32'($urandom)};
        return w;
    endfunction

    // Reference stream: datapoint-major, lane-minor; lane j of feat f sits at
    // bit 256-16*(f+1-j) of the word, y is always the top 16 bits.
    function automatic void build_exp(input int f, input int nd);
        int last;
        xfer_t x;
        exp_q.delete();
        last = (nd > DEPTH - 1) ? DEPTH - 1 : nd;
        for (int d = 0; d <= last; d++) begin
            for (int j = 0; j <= f; j++) begin
                x.dp   = 12'(d);
                x.lane = 4'(j);
                x.data = 16'(model_mem[d] >> (256 - 16 * (f + 1 - j)));
                x.is_y = (j == f);
                x.last = (j == f) && (d == last);
                exp_q.push_back(x);
            end
        end
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        wr_en = 1'b0; load_done = 1'b0; out_ready = 1'b0;
`ifdef DP_STORE_REPLAY_EN
        replay = 1'b0;
`endif
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Drives one write starting at the next falling edge; caller (or the next
    // write / start_load) takes wr_en down again.
    task automatic write_word(input logic [11:0] a, input logic [255:0] d);
        @(negedge CLK);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        if (a < DEPTH) model_mem[int'(a)] = d;
    endtask

    task automatic start_load(input int f, input int nd, input bit with_wr,
                              input logic [11:0] a, input logic [255:0] d);
        @(negedge CLK);
        feat = 4'(f); num_dp = 12'(nd); load_done = 1'b1;
        wr_en = with_wr; wr_addr = a; wr_data = d;
        if (with_wr && a < DEPTH) model_mem[int'(a)] = d;
        @(negedge CLK);
        load_done = 1'b0; wr_en = 1'b0;
    endtask

    // Records accepted transfers, idle gaps before each, and any change of the
    // presented lane while stalled. mode: 0 ready=1, 1 pattern 1,0,0,1, 2 random.
    task automatic collect(input int mode, input int max_cycles, output bit timed_out);
        xfer_t cur, prev;
        bit    prev_stall = 1'b0;
        int    gap = 0;
        obs_q.delete(); gap_q.delete();
        stall_changes = 0;
        timed_out = 1'b1;
        prev = '0;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge CLK);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((c % 4) == 0) || ((c % 4) == 3);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            cur = {out_dp, out_lane, out_data, out_is_y, out_last};
            if (prev_stall && (!out_valid || cur != prev)) stall_changes++;
            if (out_valid) begin
                if (out_ready) begin
                    obs_q.push_back(cur);
                    gap_q.push_back(gap);
                    gap = 0;
                end
                prev_stall = !out_ready;
                prev = cur;
            end else begin
                gap++;
                prev_stall = 1'b0;
            end
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        wr_en = 1'b0; load_done = 1'b0; out_ready = 1'b0;
        feat = '0; num_dp = '0; wr_addr = '0; wr_data = '0;
`ifdef DP_STORE_REPLAY_EN
        replay = 1'b0;
`endif
        @(negedge CLK);
        n_vec++;
        if ({out_valid, done, overflow} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags valid/done/ovf=%b required 000", {out_valid, done, overflow});
        end
        n_vec++;
        if ({out_data, out_lane, out_dp, out_is_y, out_last} !== '0) begin
            n_fail++;
            $display("FAIL reset_data data=%h lane=%h dp=%h y=%b last=%b required all 0",
                     out_data, out_lane, out_dp, out_is_y, out_last);
        end
        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        n_vec++;
        if ({out_valid, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_load valid/done=%b required 00", {out_valid, done});
        end
    endtask

    task automatic test_basic();
        bit to;
        logic [255:0] w;
        logic [15:0] kd [6];
        kd = '{16'h0010, 16'h00A0, 16'h0011, 16'h00A1, 16'h0012, 16'h00A2};
        for (int i = 0; i < 3; i++) begin
            w = rand_word();
            w[255:240] = 16'h00A0 + 16'(i);
            w[239:224] = 16'h0010 + 16'(i);
            write_word(12'(i), w);
        end
        start_load(1, 2, 1'b0, '0, '0);
        build_exp(1, 2);
        collect(0, 200, to);
        n_vec++;
        if (to) begin n_fail++; $display("FAIL basic_timeout done never rose"); end
        n_vec++;
        if (obs_q.size() != 6) begin
            n_fail++; $display("FAIL basic_count got %0d required 6", obs_q.size());
        end
        for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL basic_xfer[%0d] got %h required %h", i, obs_q[i], exp_q[i]);
            end
            n_vec++;
            if (obs_q[i].data !== kd[i]) begin
                n_fail++; $display("FAIL basic_const[%0d] got %h required %h", i, obs_q[i].data, kd[i]);
            end
            n_vec++;
            if (gap_q[i] != ((obs_q[i].lane == 0 && obs_q[i].dp != 0) ? 1 : 0)) begin
                n_fail++; $display("FAIL basic_gap[%0d] got %0d idle cycles", i, gap_q[i]);
            end
        end
        n_vec++;
        if ({done, out_valid} !== 2'b10) begin
            n_fail++; $display("FAIL basic_done done/valid=%b required 10", {done, out_valid});
        end
    endtask

    task automatic test_backpressure();
        bit to;
        do_reset();
        start_load(1, 2, 1'b0, '0, '0);
        build_exp(1, 2);
        collect(1, 400, to);
        n_vec++;
        if (to) begin n_fail++; $display("FAIL bp_timeout done never rose"); end
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL bp_count got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL bp_xfer[%0d] got %h required %h", i, obs_q[i], exp_q[i]);
            end
            n_vec++;
            if (gap_q[i] != ((obs_q[i].lane == 0 && obs_q[i].dp != 0) ? 1 : 0)) begin
                n_fail++; $display("FAIL bp_gap[%0d] got %0d idle cycles", i, gap_q[i]);
            end
        end
        n_vec++;
        if (stall_changes != 0) begin
            n_fail++; $display("FAIL bp_stable got %0d changes while stalled required 0", stall_changes);
        end
    endtask

    task automatic test_overflow();
        bit to;
        int f;
        do_reset();
        f = $urandom_range(0, 15);
        for (int i = 0; i < DEPTH; i++) write_word(12'(i), rand_word());
        @(negedge CLK);
        wr_en = 1'b0;
        n_vec++;
        if (overflow !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clear got %b required 0", overflow);
        end
        write_word(12'd100, rand_word());
        @(negedge CLK);
        wr_en = 1'b0;
        n_vec++;
        if (overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_set got %b required 1", overflow);
        end
        write_word(12'hFFF, rand_word());
        start_load(f, 150, 1'b0, '0, '0);
        build_exp(f, 150);
        collect(2, 8000, to);
        n_vec++;
        if (to) begin n_fail++; $display("FAIL ovf_timeout done never rose"); end
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL ovf_count got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL ovf_xfer[%0d] got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_vec++;
        if (overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_sticky got %b required 1", overflow);
        end
    endtask

    task automatic test_simultaneous();
        bit to;
        int f;
        logic [255:0] nw;
        do_reset();
        f = $urandom_range(0, 15);
        for (int i = 0; i < 4; i++) write_word(12'(i), rand_word());
        nw = rand_word();
        start_load(f, 3, 1'b1, 12'd3, nw);
        build_exp(f, 3);
        collect(0, 400, to);
        n_vec++;
        if (to) begin n_fail++; $display("FAIL simul_timeout done never rose"); end
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL simul_count got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL simul_xfer[%0d] got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        if (obs_q.size() > 0) begin
            n_vec++;
            if (obs_q[obs_q.size()-1].data !== nw[255:240]) begin
                n_fail++; $display("FAIL simul_y3 got %h required %h",
                                   obs_q[obs_q.size()-1].data, nw[255:240]);
            end
        end
    endtask

    task automatic test_async_reset();
        bit to;
        bit seen = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) write_word(12'(i), rand_word());
        start_load(3, 5, 1'b0, '0, '0);
        out_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge CLK);
            if (out_valid) begin seen = 1'b1; break; end
        end
        n_vec++;
        if (!seen) begin n_fail++; $display("FAIL arst_emit out_valid never rose"); end
        repeat (2) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        n_vec++;
        if ({out_valid, done, out_data} !== '0) begin
            n_fail++; $display("FAIL arst_now valid=%b done=%b data=%h required 0", out_valid, done, out_data);
        end
        out_ready = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            n_vec++;
            if ({out_valid, done} !== 2'b00) begin
                n_fail++; $display("FAIL arst_load[%0d] valid/done=%b required 00", c, {out_valid, done});
            end
        end
        start_load(3, 5, 1'b0, '0, '0);
        build_exp(3, 5);
        collect(0, 400, to);
        n_vec++;
        if (to) begin n_fail++; $display("FAIL arst_timeout done never rose"); end
        n_vec++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL arst_count got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_vec++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL arst_xfer[%0d] got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_feat0();
        bit to;
        logic [255:0] w;
        xfer_t first;
        do_reset();
        w = rand_word();
        write_word(12'd0, w);
        start_load(0, 0, 1'b0, '0, '0);
        collect(0, 100, to);
        n_vec++;
        if (to) begin n_fail++; $display("FAIL f0_timeout done never rose"); end
        n_vec++;
        if (obs_q.size() != 1) begin
            n_fail++; $display("FAIL f0_count got %0d required 1", obs_q.size());
        end
        first = (obs_q.size() > 0) ? obs_q[0] : '0;
        n_vec++;
        if (first !== {12'd0, 4'd0, w[255:240], 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL f0_xfer got %h required dp0 lane0 data %h y1 last1", first, w[255:240]);
        end
`ifdef DP_STORE_REPLAY_EN
        @(negedge CLK);
        replay = 1'b1;
        @(negedge CLK);
        replay = 1'b0;
        collect(0, 100, to);
        n_vec++;
        if (to || obs_q.size() != 1) begin
            n_fail++; $display("FAIL f0_replay_count got %0d timeout=%b required 1", obs_q.size(), to);
        end
        n_vec++;
        if (obs_q.size() > 0 && obs_q[0] !== {12'd0, 4'd0, w[255:240], 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL f0_replay_xfer got %h required data %h", obs_q[0], w[255:240]);
        end
`endif
    endtask

    // Entered in DONE: writes and load_done must be ignored.
    task automatic test_done_ignores();
        bit to;
        @(negedge CLK);
        wr_en = 1'b1; wr_addr = 12'd0; wr_data = ~model_mem[0];
        load_done = 1'b1; feat = 4'd0; num_dp = 12'd0;
        @(negedge CLK);
        wr_en = 1'b0; load_done = 1'b0;
        @(negedge CLK);
        n_vec++;
        if ({done, out_valid} !== 2'b10) begin
            n_fail++; $display("FAIL done_hold done/valid=%b required 10", {done, out_valid});
        end
        do_reset();
        start_load(0, 0, 1'b0, '0, '0);
        collect(0, 100, to);
        n_vec++;
        if (to || obs_q.size() != 1) begin
            n_fail++; $display("FAIL done_wr_count got %0d timeout=%b required 1", obs_q.size(), to);
        end
        n_vec++;
        if (obs_q.size() > 0 && obs_q[0].data !== model_mem[0][255:240]) begin
            n_fail++; $display("FAIL done_wr_ignored got %h required %h", obs_q[0].data, model_mem[0][255:240]);
        end
    endtask

    task automatic test_random();
        bit to;
        int f, nd;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            f  = $urandom_range(0, 15);
            nd = $urandom_range(0, 12);
            for (int a = 0; a <= nd; a++) write_word(12'(a), rand_word());
            for (int k = 0; k < 6; k++) write_word(12'($urandom_range(0, nd)), rand_word());
            start_load(f, nd, 1'b0, '0, '0);
            build_exp(f, nd);
            collect(2, 2000, to);
            n_vec++;
            if (to) begin n_fail++; $display("FAIL rnd%0d_timeout done never rose", it); end
            n_vec++;
            if (obs_q.size() != exp_q.size()) begin
                n_fail++; $display("FAIL rnd%0d_count got %0d required %0d", it, obs_q.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                n_vec++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rnd%0d_xfer[%0d] got %h required %h", it, i, obs_q[i], exp_q[i]);
                end
            end
            n_vec++;
            if (stall_changes != 0) begin
                n_fail++; $display("FAIL rnd%0d_stable got %0d changes required 0", it, stall_changes);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_simultaneous();
        test_async_reset();
        test_feat0();
        test_done_ignores();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/dp_store.md
Name: dp_store

Overview:
- Downstream neighbour of the serial deserializer in the regression front end.
- Captures each completed datapoint word (features + y) into an internal synchronous RAM at the presented address.
- After loading ends, streams the stored datapoints back one 16-bit lane per cycle to the compute stage, using a valid/ready handshake.
- Order is datapoint-major, lane-minor.

Parameters:
- ADDR_WIDTH, 12, width of datapoint address.
- MAX_FEATURES, 15, maximum feature count; lanes per word = MAX_FEATURES+1.
- LENGTH, 16, bits per lane.
- DATA_WIDTH, LENGTH*(MAX_FEATURES+1) = 256, width of one datapoint word.
- DEPTH, 100, number of RAM entries (datapoints stored).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- num_dp  in  12  last datapoint index; points 0..num_dp are valid. Sampled when load_done is accepted.
- feat  in  4  feature count; lanes used = feat+1. Sampled when load_done is accepted.
- wr_en  in  1  write strobe: one cycle per completed word.
- wr_addr  in  ADDR_WIDTH  datapoint index of the write.
- wr_data  in  DATA_WIDTH  datapoint word.
- load_done  in  1  level; end of loading.
- out_data  out  16  current lane value.
- out_lane  out  4  lane index (0..feat).
- out_dp  out  12  datapoint index.
- out_is_y  out  1  high when out_lane == feat (the y value).
- out_last  out  1  high on the final lane of the final datapoint.
- out_valid  out  1  output lane valid.
- out_ready  in  1  consumer accepts the lane.
- overflow  out  1  sticky: a write was dropped because wr_addr >= DEPTH.
- done  out  1  high in DONE.

Behaviour:
- Reset (async, RST=1):
  - state=LOAD; all outputs 0.
  - Lane, datapoint and write counters cleared.
  - RAM contents are not cleared.
  - Reset mid-stream aborts immediately; the next transfer after release starts from LOAD.
- Word lane mapping: base = DATA_WIDTH - 16*(feat+1); lane j occupies bits [base+16*j +: 16].
  - Lane feat is bits [255:240] and is always y.
  - Bits below base are ignored.
- LOAD:
  - wr_en=1 and wr_addr<DEPTH → mem[wr_addr] <= wr_data.
  - wr_en=1 and wr_addr>=DEPTH → write dropped; overflow <= 1.
  - Addresses may repeat; the last write wins.
  - load_done=1 → latch feat and num_dp; last_dp = min(num_dp, DEPTH-1); dp=0; go to FETCH.
  - wr_en and load_done in the same cycle: the write is performed, then the transition is taken.
- FETCH:
  - RAM read mem[dp]; rdata registered at this edge.
  - out_valid=0 for exactly this one cycle.
  - Next state: EMIT with lane=0.
- EMIT:
  - out_valid=1; out_data = lane slice of the registered word.
  - out_lane, out_dp, out_is_y and out_last are driven combinationally from the counters.
  - Outputs hold stable while out_valid && !out_ready.
  - Transfer when out_valid && out_ready:
    - lane<feat → lane+1; stay in EMIT (one lane per cycle at full ready).
    - lane==feat and dp<last_dp → dp+1; go to FETCH (1 bubble cycle between datapoints).
    - lane==feat and dp==last_dp → go to DONE; out_last was high on this transfer.
- DONE:
  - done=1; out_valid=0.
  - wr_en and load_done are ignored.
  - Leaves only on reset (or replay, see Optional Feature).
- feat=0: each datapoint yields a single lane, which is y (out_is_y=1 on every transfer).
- wr_en is ignored in FETCH, EMIT and DONE.
- Counter widths: lane is 4 bits, dp is 12 bits; no wrap is possible because last_dp <= DEPTH-1.

Optional Feature:
- Macro: DP_STORE_REPLAY_EN.
- When defined:
  - Adds input port replay (1 bit).
  - replay=1 in DONE → dp=0; go to FETCH, streaming the same datapoints again with feat and num_dp unchanged (multi-epoch training).
  - replay is ignored in other states.
- When undefined: no replay port; DONE is terminal until reset.

Test Plan:
1. feat=1, num_dp=2; write 3 words at addr 0..2 with y=0x00A0+i and feature=0x0010+i; load_done; out_ready=1.
   - Required response: 6 transfers in order (0,0x10),(0,0xA0),bubble,(1,0x11),(1,0xA1),bubble,(2,0x12),(2,0xA2).
   - out_is_y on lanes 1; out_last on the final transfer; then done=1.
2. Backpressure: same data with out_ready toggling 1,0,0,1.
   - Required response: out_data, out_lane and out_dp are stable while stalled.
   - No lane lost or duplicated; 6 transfers total.
3. Overflow: wr_en with wr_addr=100 and DEPTH=100.
   - Required response: overflow=1 the next cycle; mem[0..99] unchanged.
   - num_dp=150 streams only dp 0..99.
4. Simultaneous: wr_en to addr 3 in the same cycle as load_done, with num_dp=3.
   - Required response: dp 3 streams the new word.
5. Async reset asserted mid-EMIT between clock edges.
   - Required response: out_valid=0 and done=0 immediately; after release, the block is back in LOAD.
6. feat=0, num_dp=0.
   - Required response: exactly one transfer, with out_is_y=1 and out_last=1, out_data equal to bits [255:240].
   - With DP_STORE_REPLAY_EN, a replay pulse reproduces the same transfer.
